// File: rtl/ysyx_25030085_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25030085_wb_arbiter
// Description : Write-back arbiter between the ALU and the LSU for a single
//               register-file write port, plus a pending-write scoreboard
//               that decode uses for WAW and RAW hazard checks.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25030085_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  // ALU write-back requester
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  // LSU write-back requester
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  // Decode-side scoreboard interface
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1_addr,
  output logic            rs1_pending,
  // Pipeline control
  input  logic            flush,
  // Register-file write port
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
  localparam int         NREGS        = 32;

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [3:0]       starve_cnt;
  logic [3:0]       starve_nxt;
  logic             starve_hit;

  logic             alu_fire;
  logic             lsu_fire;
  logic             wb_fire;
  logic [4:0]       win_rd;
  logic [XLEN-1:0]  win_data;

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             issue_set;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // The ALU is owed a grant once it has lost STARVE_MAX contended cycles in
  // a row. Each ready is built from the other side's valid, never its ready,
  // so there is no combinational loop between the two requesters.
  assign starve_hit = (starve_cnt == STARVE_LIMIT);
  assign alu_ready  = alu_valid & (~lsu_valid | starve_hit);
  assign lsu_ready  = lsu_valid & ~(alu_valid & starve_hit);

  assign alu_fire = alu_valid & alu_ready;
  assign lsu_fire = lsu_valid & lsu_ready;
  assign wb_fire  = alu_fire | lsu_fire;

  // Select the address and data of whichever requester won this cycle
  always_comb begin
    win_rd   = lsu_rd;
    win_data = lsu_data;
    if (alu_fire) begin
      win_rd   = alu_rd;
      win_data = alu_data;
    end
  end

  // Starvation counter next state: count lost ALU cycles, saturate, clear
  // on a grant, an idle ALU or a flush
  always_comb begin
    starve_nxt = 4'd0;
    if (!flush && alu_valid && !alu_ready) begin
      if (starve_hit) begin
        starve_nxt = starve_cnt;
      end else begin
        starve_nxt = starve_cnt + 4'd1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered register-file write port
  // --------------------------------------------------------------------------
  // A transfer is presented to the register file one cycle after it is
  // accepted. Writes to x0 are accepted but never enabled. Address and data
  // only move on a transfer so they hold across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_fire & (win_rd != 5'd0);
      if (wb_fire) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending-write scoreboard
  // --------------------------------------------------------------------------
  // An instruction may issue unless its destination already has a write in
  // flight; x0 never carries a pending write.
  assign issue_ready = (issue_rd == 5'd0) | ~pending[issue_rd];
  assign issue_set   = issue_valid & issue_ready & (issue_rd != 5'd0);
  assign rs1_pending = pending[rs1_addr];

  // Scoreboard next state: retire the write on the port, then mark the newly
  // issued destination so that a same-edge set beats the clear; flush wipes all
  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (issue_set) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    if (flush) begin
      pending_nxt = '0;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030085_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25030085_wb_arbiter
// Description : Randomised, scoreboard-checked bench for the write-back
//               arbiter, with directed sequences for the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25030085_wb_arbiter;

  localparam int XLEN = 32;
  localparam int SMAX = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1_addr;
  logic            rs1_pending;
  logic            flush;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  ysyx_25030085_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs1_pending(rs1_pending), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        av; bit [4:0] ar; bit [31:0] ad;
    bit        lv; bit [4:0] lr; bit [31:0] ld;
    bit        iv; bit [4:0] ir;
    bit [4:0]  rs1;
    bit        fl;
  } stim_t;

  typedef struct {
    bit ar; bit lr; bit ir; bit rp; bit we; bit [4:0] wa; bit [31:0] wd;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: what the register file port shows now, which
  // registers have writes in flight, and how many contended cycles in a row
  // the ALU has lost.
  int        m_starve;
  bit        m_pend[32];
  bit        m_we;
  bit [4:0]  m_wa;
  bit [31:0] m_wd;

  function automatic void model_reset();
    m_starve = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0;
    m_wa = 5'd0;
    m_wd = 32'd0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Apply one cycle of stimulus, record the expected response, advance model
  task automatic drive(input stim_t s, output bit a_acc, output bit l_acc);
    exp_t e;
    @(posedge clk); #1;
    alu_valid = s.av; alu_rd = s.ar; alu_data = s.ad;
    lsu_valid = s.lv; lsu_rd = s.lr; lsu_data = s.ld;
    issue_valid = s.iv; issue_rd = s.ir; rs1_addr = s.rs1; flush = s.fl;

    // LSU has priority unless the ALU has already lost SMAX times in a row
    a_acc = s.av && (!s.lv || m_starve >= SMAX);
    l_acc = s.lv && !a_acc;
    e.ar = a_acc;
    e.lr = l_acc;
    e.ir = (s.ir == 5'd0) || !m_pend[s.ir];
    e.rp = m_pend[s.rs1];
    e.we = m_we;
    e.wa = m_wa;
    e.wd = m_wd;
    expq.push_back(e);

    if (s.fl)                 m_starve = 0;
    else if (s.av && !a_acc)  m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    else                      m_starve = 0;

    if (s.fl) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      if (m_we) m_pend[m_wa] = 1'b0;
      if (s.iv && e.ir && s.ir != 5'd0) m_pend[s.ir] = 1'b1;
    end

    if (a_acc) begin
      m_we = (s.ar != 5'd0); m_wa = s.ar; m_wd = s.ad;
    end else if (l_acc) begin
      m_we = (s.lr != 5'd0); m_wa = s.lr; m_wd = s.ld;
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && expq.size() > 0) begin
        e = expq.pop_front();
        chk("alu_ready",   alu_ready,   e.ar);
        chk("lsu_ready",   lsu_ready,   e.lr);
        chk("ready_excl",  alu_ready & lsu_ready, 1'b0);
        chk("issue_ready", issue_ready, e.ir);
        chk("rs1_pending", rs1_pending, e.rp);
        chk("rf_we",       rf_we,       e.we);
        if (e.we) begin
          chk("rf_waddr", rf_waddr, e.wa);
          chk("rf_wdata", rf_wdata, e.wd);
        end
      end
    end
  end

  initial begin
    stim_t s;
    bit    a, l;
    bit    hold_a, hold_l;
    stim_t r;

    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 5'd3; flush = 0;
    model_reset();
    #2;
    chk("reset_rf_we",    rf_we,       1'b0);
    chk("reset_rf_waddr", rf_waddr,    5'd0);
    chk("reset_rf_wdata", rf_wdata,    32'd0);
    chk("reset_pending",  rs1_pending, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Lone ALU write: accepted at once, written next cycle, then idle
    s = idle(); s.av = 1; s.ar = 5'd5; s.ad = 32'h1234_5678;
    drive(s, a, l);
    drive(idle(), a, l);
    drive(idle(), a, l);

    // Continuous contention: ALU holds its request until granted
    s = idle(); s.av = 1; s.ar = 5'd3; s.ad = 32'hAAAA_0003;
    s.lv = 1; s.lr = 5'd4;
    for (int i = 0; i < 6; i++) begin
      s.ld = 32'h5555_0000 + i;
      drive(s, a, l);
      if (a) s.ad = 32'hAAAA_1000 + i;
    end
    drive(idle(), a, l);

    // Scoreboard set, RAW visibility, and clear by an ALU write
    s = idle(); s.iv = 1; s.ir = 5'd7; s.rs1 = 5'd7;
    drive(s, a, l);
    drive(s, a, l);
    s = idle(); s.av = 1; s.ar = 5'd7; s.ad = 32'hC0DE_0007; s.rs1 = 5'd7;
    drive(s, a, l);
    s = idle(); s.rs1 = 5'd7;
    drive(s, a, l);
    drive(s, a, l);

    // Same-edge set and clear on x9: the set must survive
    s = idle(); s.av = 1; s.ar = 5'd9; s.ad = 32'h0000_0009;
    drive(s, a, l);
    s = idle(); s.iv = 1; s.ir = 5'd9; s.rs1 = 5'd9;
    drive(s, a, l);
    s = idle(); s.rs1 = 5'd9; s.iv = 1; s.ir = 5'd9;
    drive(s, a, l);

    // LSU write to x0 is accepted but never enabled; x0 never pending
    s = idle(); s.lv = 1; s.lr = 5'd0; s.ld = 32'hFFFF_FFFF; s.rs1 = 5'd0;
    drive(s, a, l);
    s = idle(); s.rs1 = 5'd0; s.iv = 1; s.ir = 5'd0;
    drive(s, a, l);

    // Flush: clears pending, registered write still presented, flush-cycle
    // transfer still written
    s = idle(); s.iv = 1; s.ir = 5'd12; s.lv = 1; s.lr = 5'd13; s.ld = 32'h1313_1313;
    drive(s, a, l);
    s = idle(); s.fl = 1; s.av = 1; s.ar = 5'd15; s.ad = 32'h1515_1515; s.rs1 = 5'd12;
    drive(s, a, l);
    s = idle(); s.rs1 = 5'd12; s.iv = 1; s.ir = 5'd9;
    drive(s, a, l);
    drive(idle(), a, l);

    // Randomised traffic; requesters hold their request until accepted
    hold_a = 0; hold_l = 0;
    r = idle();
    for (int i = 0; i < 1500; i++) begin
      if (!hold_a) begin
        r.av = ($urandom_range(0, 3) != 0);
        r.ar = 5'($urandom_range(0, 31));
        r.ad = $urandom;
      end
      if (!hold_l) begin
        r.lv = ($urandom_range(0, 3) != 0);
        r.lr = 5'($urandom_range(0, 31));
        r.ld = $urandom;
      end
      r.iv  = ($urandom_range(0, 1) != 0);
      r.ir  = 5'($urandom_range(0, 31));
      r.rs1 = 5'($urandom_range(0, 31));
      r.fl  = ($urandom_range(0, 19) == 0);
      drive(r, a, l);
      hold_a = r.av && !a;
      hold_l = r.lv && !l;
    end
    drive(idle(), a, l);

    // Asynchronous reset between a write's acceptance and its end
    s = idle(); s.iv = 1; s.ir = 5'd7;
    drive(s, a, l);
    s = idle(); s.av = 1; s.ar = 5'd5; s.ad = 32'hDEAD_BEEF;
    drive(s, a, l);
    @(posedge clk); #2;
    alu_valid = 0; issue_valid = 0;
    chk("pre_reset_rf_we", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rf_we",    rf_we,    1'b0);
    chk("async_rf_waddr", rf_waddr, 5'd0);
    chk("async_rf_wdata", rf_wdata, 32'd0);
    model_reset();
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s = idle(); s.rs1 = 5'd7; s.iv = 1; s.ir = 5'd7;
    drive(s, a, l);
    s = idle(); s.rs1 = 5'd7;
    drive(s, a, l);

    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25030085_wb_arbiter.md
YSYX_25030085_WB_ARBITER -- requirements
Module: ysyx_25030085_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of the register-file write port.
REQ-002 Parameter STARVE_MAX, default 3, consecutive lost ALU arbitration cycles before the ALU is force-granted (range 1..15).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port alu_valid  input  1  ALU write-back request.
REQ-006 Port alu_rd  input  5  ALU destination register.
REQ-007 Port alu_data  input  XLEN  ALU result.
REQ-008 Port alu_ready  output  1  ALU request accepted this cycle.
REQ-009 Port lsu_valid  input  1  load write-back request.
REQ-010 Port lsu_rd  input  5  load destination register.
REQ-011 Port lsu_data  input  XLEN  load data.
REQ-012 Port lsu_ready  output  1  LSU request accepted this cycle.
REQ-013 Port issue_valid  input  1  decode issues an instruction that will write issue_rd.
REQ-014 Port issue_rd  input  5  destination register of the issuing instruction.
REQ-015 Port issue_ready  output  1  issue permitted (no WAW hazard).
REQ-016 Port rs1_addr  input  5  source register queried by decode.
REQ-017 Port rs1_pending  output  1  rs1_addr has an outstanding write.
REQ-018 Port flush  input  1  synchronous pipeline flush.
REQ-019 Port rf_we  output  1  register-file write enable.
REQ-020 Port rf_waddr  output  5  register-file write address.
REQ-021 Port rf_wdata  output  XLEN  register-file write data.

Function
REQ-022 Handshake: a transfer SHALL occur on a cycle with valid and ready both high; ready SHALL be combinational and SHALL NOT depend on the ready of the other requester.
REQ-023 Grant rule: at most one of alu_ready and lsu_ready SHALL be high per cycle; a lone requester SHALL be granted immediately.
REQ-024 Contention: LSU SHALL win by default; when starve_cnt equals STARVE_MAX, ALU SHALL win instead.
REQ-025 starve_cnt (4-bit) SHALL increment on each cycle with alu_valid high and alu_ready low, SHALL clear on an ALU grant or when alu_valid is low, and SHALL saturate at STARVE_MAX.
REQ-026 Write port is registered: a transfer in cycle N SHALL produce rf_we=1, rf_waddr=rd, rf_wdata=data in cycle N+1 only; with no transfer, rf_we SHALL be 0 in the next cycle, and rf_waddr/rf_wdata SHALL hold their values.
REQ-027 A transfer with rd=0 SHALL be accepted (ready high) but SHALL produce rf_we=0.
REQ-028 Scoreboard: a 32-bit pending vector; bit 0 SHALL be constant 0.
REQ-029 Setting: issue_valid and issue_ready both high with issue_rd!=0 SHALL set pending[issue_rd] at the next edge.
REQ-030 Clearing: a cycle with rf_we=1 SHALL clear pending[rf_waddr] at the same edge.
REQ-031 Simultaneous set and clear of the same bit: set SHALL win.
REQ-032 issue_ready = (issue_rd==0) or not pending[issue_rd]; rs1_pending = pending[rs1_addr]; both combinational.
REQ-033 flush SHALL clear pending and starve_cnt at the next edge, overriding REQ-029/030; a write already registered on rf_we SHALL still be presented, and transfers in the flush cycle SHALL still be accepted and written.
REQ-034 Requesters SHALL hold valid, rd and data stable until accepted; the block SHALL NOT check this.

Reset
REQ-035 rst_n low SHALL immediately force rf_we=0, rf_waddr=0, rf_wdata=0, pending=0 and starve_cnt=0, independent of clk.
REQ-036 After rst_n deasserts, the first transfer SHALL be accepted on the first rising edge with valid high.
REQ-037 Reset asserted between a transfer and its write cycle SHALL suppress that write (rf_we stays 0).

Verification
REQ-038 ALU only: alu_valid=1, rd=5, data=0x12345678 at cycle N -> alu_ready=1 at N; at N+1 rf_we=1, rf_waddr=5, rf_wdata=0x12345678; at N+2 rf_we=0.
REQ-039 Contention, STARVE_MAX=3: both valid continuously -> lsu_ready in cycles 0-2, alu_ready in cycle 3, lsu_ready in cycle 4; no cycle has both ready signals high.
REQ-040 Scoreboard: issue rd=7 -> the next cycle shows issue_ready=0 for rd=7 and rs1_pending=1 for rs1_addr=7; an ALU write to rd=7 -> rs1_pending=0 on the cycle after rf_we=1.
REQ-041 Same-edge set and clear: rf_we=1 to x9 while issuing rd=9 -> pending[9] remains 1.
REQ-042 rd=0 LSU transfer with data=0xFFFFFFFF -> lsu_ready=1, rf_we=0 the next cycle; rs1_pending for x0 is always 0.
REQ-043 Async reset mid-write: transfer at N, rst_n low between edges N and N+1 -> rf_we=0 immediately; pending=0 after reset release.
